// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: drives the PC to instruction memory and holds one
// IF/ID entry with valid/ready handshake, redirect flush and misaligned-target fault.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          W        = 32
) (
    input  logic         CLK,
    input  logic         RST_n,
    output logic [W-1:0] imem_addr,
    input  logic [W-1:0] imem_rdata,
    input  logic         redirect_valid,
    input  logic [W-1:0] redirect_pc,
    input  logic         id_ready,
    output logic         id_valid,
    output logic [W-1:0] id_instr,
    output logic [W-1:0] id_pc,
    output logic [W-1:0] id_pc_plus4,
    output logic         fault,
    output logic [W-1:0] fault_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [W-1:0] PC_STEP  = W'(4);
    localparam logic [W-1:0] PC_RESET = RESET_PC[W-1:0];

    state_t         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic           id_valid_q, id_valid_d;
    logic [W-1:0]   id_instr_q, id_instr_d;
    logic [W-1:0]   id_pc_q, id_pc_d;
    logic [W-1:0]   id_pc_plus4_q, id_pc_plus4_d;
    logic           fault_q, fault_d;
    logic [W-1:0]   fault_pc_q, fault_pc_d;
    logic [W-1:0]   pc_plus4;

    // Wraps naturally modulo 2^W.
    assign pc_plus4 = pc_q + PC_STEP;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;

        if (redirect_valid) begin
            // Redirect beats fetch and stall; a coincident transfer has already completed.
            id_valid_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = FAULT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else begin
                state_d = RUN;
                pc_d    = redirect_pc;
                fault_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (!id_valid_q || id_ready) begin
                        id_instr_d    = imem_rdata;
                        id_pc_d       = pc_q;
                        id_pc_plus4_d = pc_plus4;
                        id_valid_d    = 1'b1;
                        pc_d          = pc_plus4;
                    end
                end
                FAULT: begin
                    id_valid_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q       <= IDLE;
            pc_q          <= PC_RESET;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;

endmodule
